// File: rtl/aukv_pkg.sv
// Shared constants for the AUKV integer register file: datapath width,
// legal register-file depths and the hard-wired zero register.
package aukv_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned NREG_RV32E = 16;
  localparam int unsigned NREG_RV32I = 32;
  localparam int unsigned REG0_ADDR  = 0;

  function automatic bit nreg_is_legal(input int unsigned n);
    return (n == NREG_RV32E) || (n == NREG_RV32I);
  endfunction

endpackage

// File: rtl/aukv_rf_rdport.sv
// One combinational read port: array mux, write-through bypass (port 1 wins)
// and busy qualification against same-cycle writebacks.
module aukv_rf_rdport
  import aukv_pkg::*;
#(
  parameter int unsigned XLEN = aukv_pkg::XLEN,
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = 5
) (
  input  logic [AW-1:0]        i_addr,
  input  logic [NREG*XLEN-1:0] i_rf_flat,
  input  logic [NREG-1:0]      i_busy,
  input  logic                 i_w0_en,
  input  logic [AW-1:0]        i_w0_addr,
  input  logic [XLEN-1:0]      i_w0_data,
  input  logic                 i_w1_en,
  input  logic [AW-1:0]        i_w1_addr,
  input  logic [XLEN-1:0]      i_w1_data,
  output logic [XLEN-1:0]      o_data,
  output logic                 o_busy
);

  logic            w_is_x0;
  logic            w_hit0;
  logic            w_hit1;
  logic [XLEN-1:0] w_rf_word;

  assign w_is_x0   = (i_addr == AW'(REG0_ADDR));
  assign w_hit0    = i_w0_en && (i_w0_addr == i_addr) && !w_is_x0;
  assign w_hit1    = i_w1_en && (i_w1_addr == i_addr) && !w_is_x0;
  assign w_rf_word = i_rf_flat[i_addr*XLEN +: XLEN];

  always_comb begin
    o_data = w_rf_word;
    if (w_is_x0)     o_data = '0;
    else if (w_hit1) o_data = i_w1_data;
    else if (w_hit0) o_data = i_w0_data;
  end

  // A pending register being written back this cycle is already resolved.
  assign o_busy = i_busy[i_addr] && !w_hit0 && !w_hit1 && !w_is_x0;

endmodule

// File: rtl/aukv_gpr_regfile_sb.sv
// Integer register file with two write ports, NRP bypassed read ports and a
// per-register pending-write scoreboard.
module aukv_gpr_regfile_sb
  import aukv_pkg::*;
#(
  parameter int unsigned XLEN = aukv_pkg::XLEN,
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = 5,
  parameter int unsigned NRP  = 2
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic [NRP*AW-1:0]   i_rs_addr,
  output logic [NRP*XLEN-1:0] o_rs_data,
  output logic [NRP-1:0]      o_rs_busy,
  input  logic                i_w0_en,
  input  logic [AW-1:0]       i_w0_addr,
  input  logic [XLEN-1:0]     i_w0_data,
  input  logic                i_w1_en,
  input  logic [AW-1:0]       i_w1_addr,
  input  logic [XLEN-1:0]     i_w1_data,
  input  logic                i_sb_set,
  input  logic [AW-1:0]       i_sb_addr,
  input  logic                i_flush,
  output logic                o_any_busy
);

  logic [XLEN-1:0]      r_rf [NREG];
  logic [NREG-1:0]      r_busy;
  logic [NREG*XLEN-1:0] w_rf_flat;

  // Entry 0 is only ever loaded by reset, so it stays zero.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int unsigned i = 0; i < NREG; i++) r_rf[i] <= '0;
    end else begin
      for (int unsigned i = REG0_ADDR + 1; i < NREG; i++) begin
        if (i_w1_en && (i_w1_addr == AW'(i)))      r_rf[i] <= i_w1_data;
        else if (i_w0_en && (i_w0_addr == AW'(i))) r_rf[i] <= i_w0_data;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_busy <= '0;
    end else if (i_flush) begin
      r_busy <= '0;
    end else begin
      for (int unsigned i = REG0_ADDR + 1; i < NREG; i++) begin
        if (i_sb_set && (i_sb_addr == AW'(i)))
          r_busy[i] <= 1'b1;
        else if ((i_w0_en && (i_w0_addr == AW'(i))) || (i_w1_en && (i_w1_addr == AW'(i))))
          r_busy[i] <= 1'b0;
      end
    end
  end

  always_comb begin
    w_rf_flat = '0;
    for (int unsigned i = 0; i < NREG; i++) w_rf_flat[i*XLEN +: XLEN] = r_rf[i];
  end

  assign o_any_busy = |r_busy;

  for (genvar k = 0; k < NRP; k++) begin : g_rdport
    aukv_rf_rdport #(
      .XLEN(XLEN),
      .NREG(NREG),
      .AW  (AW)
    ) u_rdport (
      .i_addr   (i_rs_addr[k*AW +: AW]),
      .i_rf_flat(w_rf_flat),
      .i_busy   (r_busy),
      .i_w0_en  (i_w0_en),
      .i_w0_addr(i_w0_addr),
      .i_w0_data(i_w0_data),
      .i_w1_en  (i_w1_en),
      .i_w1_addr(i_w1_addr),
      .i_w1_data(i_w1_data),
      .o_data   (o_rs_data[k*XLEN +: XLEN]),
      .o_busy   (o_rs_busy[k])
    );
  end

endmodule

// File: doc/aukv_gpr_regfile_sb.md
AUKV_GPR_REGFILE_SB -- requirements
Module: aukv_gpr_regfile_sb

Interface
REQ-001 Parameters SHALL be, as name, default, meaning: XLEN, 32, register width in bits; NREG, 32, number of registers (16 or 32 only); AW, 5, address width, equal to log2(NREG); NRP, 2, number of read ports (1..4).
REQ-002 Ports SHALL be, as name, direction, width, meaning:
- i_clk, in, 1, single clock, rising edge.
- i_rstn, in, 1, reset, asynchronous, active-low.
- i_rs_addr, in, NRP*AW, read addresses, port k at bits [k*AW +: AW].
- o_rs_data, out, NRP*XLEN, read data, port k at bits [k*XLEN +: XLEN].
- o_rs_busy, out, NRP, port k source has a pending write.
- i_w0_en, in, 1, write port 0 (ALU writeback) enable.
- i_w0_addr, in, AW, write port 0 destination.
- i_w0_data, in, XLEN, write port 0 data.
- i_w1_en, in, 1, write port 1 (load return) enable.
- i_w1_addr, in, AW, write port 1 destination.
- i_w1_data, in, XLEN, write port 1 data.
- i_sb_set, in, 1, mark a register pending (instruction issue).
- i_sb_addr, in, AW, register to mark.
- i_flush, in, 1, synchronous clear of all pending marks.
- o_any_busy, out, 1, OR of all pending marks.

Function
REQ-003 Register 0 SHALL read as zero, SHALL ignore writes, and SHALL never be marked pending.
REQ-004 An enabled write SHALL update the addressed register at the rising edge of i_clk.
REQ-005 When both write ports are enabled to the same nonzero address, the module SHALL store i_w1_data.
REQ-006 Reads SHALL be combinational, with zero-cycle latency.
REQ-007 When a read address equals an enabled write address in the same cycle, o_rs_data SHALL return that write's data (write-through bypass), applying the port-1 priority of REQ-005.
REQ-008 The module SHALL hold a scoreboard of NREG busy bits.
REQ-009 An enabled write to address a SHALL clear busy[a] at the next edge.
REQ-010 i_sb_set SHALL set busy[i_sb_addr] at the next edge.
REQ-011 When set and clear hit the same address in one cycle, the set SHALL win.
REQ-012 i_flush SHALL clear all busy bits at the next edge; it SHALL take priority over i_sb_set and SHALL NOT affect register contents.
REQ-013 o_rs_busy[k] SHALL equal busy[addr_k] AND NOT (an enabled write to addr_k in the current cycle).
REQ-014 o_rs_busy[k] SHALL be 0 when addr_k is 0.
REQ-015 o_any_busy SHALL reflect the registered busy bits only, with no bypass.
REQ-016 All read ports SHALL be independent, and any number of ports SHALL be able to read the same address at once.

Reset
REQ-017 While i_rstn is 0, every register and every busy bit SHALL be 0, asynchronously.
REQ-018 During reset, o_rs_data SHALL read 0 for any address not being written, and o_rs_busy and o_any_busy SHALL be 0.
REQ-019 A write or set asserted during reset SHALL be discarded.
REQ-020 The first edge after i_rstn rises SHALL operate normally.

Structure
REQ-021 The shared package aukv_pkg SHALL hold XLEN, the NREG choices, and the register-0 address constant.
REQ-022 The read port SHALL be a sub-module, aukv_rf_rdport (mux, bypass, busy qualification), generated NRP times.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Reset, then read all addresses on every port: data 0, busy 0, o_any_busy 0.
- Write x5=0xDEADBEEF on w0 while reading x5 in the same cycle: o_rs_data 0xDEADBEEF that cycle; next cycle x5 still reads 0xDEADBEEF.
- w0 x7=0x11 and w1 x7=0x22 in one cycle: x7 reads 0x22 after the edge, and reads 0x22 via bypass in that cycle.
- Write x0=0xFFFFFFFF with i_sb_set for x0: x0 reads 0, busy 0.
- i_sb_set x3, then x3 busy=1 and o_any_busy=1; w1 x3=0x44 the next cycle gives busy=0 that cycle via bypass and data 0x44; set plus write on x3 in one cycle leaves busy=1.
- Set x1, x2, x9, then i_flush with i_sb_set x4: all busy bits 0 and data unchanged; assert i_rstn=0 mid-sequence and all registers read 0 immediately.
